pc_fetch_unit: RTL
==================

# pc_fetch_unit

Program-counter register and fetch sequencer at the head of the RISC-V fetch stage. Holds the current PC and drives it to the PC+4 incrementer and to instruction memory. Advances the PC with the incrementer result on each accepted fetch, or loads a branch/jump target on a redirect. Provides the valid/ready fetch handshake, stall handling and an accepted-fetch counter.

## Interface
Parameters:
- XLEN, 32, address width
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- pc_actual  output  XLEN  current PC register; feeds the external PC+4 incrementer
- pc_siguiente  input  XLEN  incrementer result (pc_actual + 4), combinational return path
- fetch_valid  output  1  fetch request valid
- fetch_addr  output  XLEN  fetch address; always equals pc_actual
- fetch_ready  input  1  instruction memory accepts the request
- stall  input  1  downstream back-pressure; blocks new requests
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_target  input  XLEN  new PC when redirect_valid=1
- fetch_count  output  32  number of accepted fetches (valid & ready), wraps modulo 2^32
- trap_valid  output  1  one-cycle pulse: misaligned redirect target
- trap_addr  output  XLEN  offending target, held until the next trap

## Operation
- States: RST_HOLD, FETCH, TRAP.
- Reset, asynchronous on rst_n=0:
  - pc_actual=RESET_VECTOR, fetch_valid=0, fetch_count=0, trap_valid=0, trap_addr=0.
  - State RST_HOLD.
- RST_HOLD: one cycle after rst_n deasserts, go to FETCH. fetch_valid=0 throughout.
- FETCH:
  - fetch_valid=1 unless stall=1 and no request is pending.
  - Once fetch_valid=1 it stays high with a stable fetch_addr until fetch_ready=1. stall cannot withdraw a pending request.
- Accept (fetch_valid & fetch_ready):
  - pc_actual <= pc_siguiente.
  - fetch_count <= fetch_count+1.
- Redirect priority: redirect_valid=1 overrides accept.
  - pc_actual <= redirect_target in every case.
  - If it coincides with an accept, the accept still increments fetch_count.
  - A pending, unaccepted request is replaced: fetch_addr changes to the target next cycle and fetch_valid stays 1. This is the only permitted change of fetch_addr while valid.
- redirect_valid in RST_HOLD is ignored.
- fetch_count 32'hFFFF_FFFF + accept -> 0.
- pc_siguiente wrap (PC 32'hFFFF_FFFC -> 0) is accepted without special handling.

## Timing
- fetch_addr is combinational from pc_actual, with zero latency.
- fetch_valid is registered. The first request is visible 2 cycles after the rst_n rising edge (RST_HOLD, then FETCH).
- Back-to-back accepts sustain 1 fetch/cycle while fetch_ready=1 and stall=0.
- Redirect-to-request latency is 1 cycle: target appears on fetch_addr the edge after redirect_valid.
- stall=1 with no pending request: fetch_valid drops on the next edge. stall=0 re-raises it on the following edge.
- rst_n asserted mid-transaction: all outputs return to reset values immediately, and the pending request is abandoned.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - redirect_target[1:0]!=0 suppresses the PC load.
  - Pulses trap_valid for 1 cycle and captures trap_addr=redirect_target.
  - Enters TRAP, where fetch_valid=0.
  - TRAP is left only by an aligned redirect, which loads the target and returns to FETCH. Misaligned redirects in TRAP re-trap.
- Not defined: redirect_target[1:0] is forced to 2'b00 on load, TRAP is unreachable, and trap_valid/trap_addr are tied to 0.

## Structure
- Shared package:
  - state enum (RST_HOLD, FETCH, TRAP)
  - XLEN default
  - RESET_VECTOR default
  - instruction-size constant (4)
  - alignment mask 2'b11
- One sub-module, pc_next_mux: combinational next-PC select (redirect target / pc_siguiente / hold) with the alignment check. The top level keeps the registers, FSM and counter.
- The incrementer stays external, connected via pc_actual/pc_siguiente.

## Test plan
- Reset release, fetch_ready=1: fetch_addr sequence 0,4,8,C from the second cycle after release; fetch_count=4 after 4 accepts.
- fetch_ready=0 for 3 cycles with stall toggling: fetch_valid stays 1 and fetch_addr stays 8; no count change.
- redirect_valid with target 32'h0000_0100 on the same cycle as an accept at 0xC: next fetch_addr=0x100; fetch_count increments once.
- Macro on, target 32'h0000_0102: trap_valid pulse, trap_addr=0x102, fetch_valid=0; then target 0x200 resumes fetch at 0x200. Macro off, same target: fetch_addr=0x100, no trap.
- rst_n low mid-request at PC 0x40: pc_actual=RESET_VECTOR and fetch_valid=0 asynchronously; fetch_count=0.
- fetch_count preset near wrap (force 32'hFFFF_FFFF) + 1 accept -> 0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared state encoding and fetch constants for the PC fetch unit.
package pc_fetch_unit_pkg;
    typedef enum logic [1:0] {RST_HOLD, FETCH, TRAP} state_e;
    localparam int          XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [1:0]  ALIGN_MASK       = 2'(INSTR_BYTES - 1);
endpackage

// File: rtl/pc_fetch_unit_next_mux.sv
// pc_next_mux: next-PC select (redirect / incrementer / hold) with alignment check.
// Misaligned targets trap only when PC_MISALIGN_TRAP_EN is defined; otherwise they are force-aligned.
module pc_next_mux
    import pc_fetch_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] pc_actual_i,
    input  logic [XLEN-1:0] pc_siguiente_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            redirect_i,
    input  logic            accept_i,
    output logic [XLEN-1:0] pc_d_o,
    output logic            misaligned_o
);
    logic [XLEN-1:0] tgt;
`ifdef PC_MISALIGN_TRAP_EN
    assign misaligned_o = redirect_i && ((redirect_target_i[1:0] & ALIGN_MASK) != 2'b00);
    assign tgt          = redirect_target_i;
`else
    assign misaligned_o = 1'b0;
    assign tgt          = redirect_target_i & ~XLEN'(ALIGN_MASK);
`endif
    assign pc_d_o = misaligned_o ? pc_actual_i :
                    redirect_i   ? tgt :
                    accept_i     ? pc_siguiente_i : pc_actual_i;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, fetch handshake FSM and accepted-fetch counter.
// Optional misaligned-redirect trap enabled by PC_MISALIGN_TRAP_EN.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc_actual,
    input  logic [XLEN-1:0] pc_siguiente,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_addr,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [31:0]     fetch_count,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_addr
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, trap_addr_q, trap_addr_d;
    logic            fetch_valid_q, fetch_valid_d, trap_valid_q, trap_valid_d;
    logic [31:0]     fetch_count_q;
    logic            accept, redir, misaligned;

    assign accept = fetch_valid_q && fetch_ready;
    assign redir  = redirect_valid && (state_q != RST_HOLD);

    pc_next_mux #(.XLEN(XLEN)) u_next_mux (
        .pc_actual_i      (pc_q),
        .pc_siguiente_i   (pc_siguiente),
        .redirect_target_i(redirect_target),
        .redirect_i       (redir),
        .accept_i         (accept),
        .pc_d_o           (pc_d),
        .misaligned_o     (misaligned)
    );

    always_comb begin
        state_d       = state_q;
        fetch_valid_d = 1'b0;
        trap_valid_d  = 1'b0;
        trap_addr_d   = trap_addr_q;
        if (state_q == RST_HOLD) begin
            state_d = FETCH;
        end else if (misaligned) begin
            state_d      = TRAP;
            trap_valid_d = 1'b1;
            trap_addr_d  = redirect_target;
        end else if (state_q == FETCH || redir) begin
            // A pending request survives stall; only a fresh request is held back.
            state_d       = FETCH;
            fetch_valid_d = (fetch_valid_q && !accept) || !stall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RST_HOLD;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            fetch_count_q <= '0;
            trap_valid_q  <= 1'b0;
            trap_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_count_q <= fetch_count_q + 32'(accept);
            trap_valid_q  <= trap_valid_d;
            trap_addr_q   <= trap_addr_d;
        end
    end

    assign pc_actual   = pc_q;
    assign fetch_addr  = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_count = fetch_count_q;
    assign trap_valid  = trap_valid_q;
    assign trap_addr   = trap_addr_q;
endmodule
